// File: rtl/rgb_avg_pkg.sv
// ============================================================================
// Module : rgb_avg_pkg
// Brief  : Shared widths, FSM states and colour-class codes for rgb_frame_avg.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package rgb_avg_pkg;

  localparam int CH_W  = 8;
  localparam int RGB_W = 3 * CH_W;
  localparam int X_W   = 12;
  localparam int Y_W   = 11;

  localparam logic [1:0] CLASS_NEUTRAL = 2'd0;
  localparam logic [1:0] CLASS_RED     = 2'd1;
  localparam logic [1:0] CLASS_GREEN   = 2'd2;
  localparam logic [1:0] CLASS_BLUE    = 2'd3;
  localparam int         CLASS_MARGIN  = 32;

  typedef enum logic [1:0] {
    ST_WAIT_FRAME = 2'd0,
    ST_ACCUM      = 2'd1,
    ST_FINISH     = 2'd2
  } avg_state_t;

  // A channel wins only if it beats both others by the margin; 9 bits hold the biased sum.
  function automatic logic [1:0] classify(input logic [RGB_W-1:0] rgb);
    logic [CH_W:0] r, g, b, m;
    r = {1'b0, rgb[23:16]};
    g = {1'b0, rgb[15:8]};
    b = {1'b0, rgb[7:0]};
    m = 9'(CLASS_MARGIN);
    if (r >= g + m && r >= b + m)      classify = CLASS_RED;
    else if (g >= r + m && g >= b + m) classify = CLASS_GREEN;
    else if (b >= r + m && b >= g + m) classify = CLASS_BLUE;
    else                               classify = CLASS_NEUTRAL;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rgb_win_counter.sv
// ============================================================================
// Module : rgb_win_counter
// Brief  : Column/row tracking from VDE/HSync/VSync and averaging-window decode.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rgb_win_counter
  import rgb_avg_pkg::*;
#(
  parameter int WIN_X0     = 608,
  parameter int WIN_Y0     = 328,
  parameter int WIN_W_LOG2 = 6,
  parameter int WIN_H_LOG2 = 6
) (
  input  logic clk,
  input  logic rst,
  input  logic hsync,
  input  logic vsync,
  input  logic vde,
  output logic in_window,
  output logic vsync_rise
);

  localparam int X_HI = WIN_X0 + (2 ** WIN_W_LOG2);
  localparam int Y_HI = WIN_Y0 + (2 ** WIN_H_LOG2);

  logic [X_W-1:0] r_x;
  logic [Y_W-1:0] r_y;
  logic           r_vde_d;
  logic           r_hsync_d;
  logic           r_vsync_d;
  logic           w_vde_fall;
  logic           w_hsync_rise;
  logic           w_x_in;
  logic           w_y_in;

  assign w_vde_fall   = r_vde_d & ~vde;
  assign w_hsync_rise = hsync & ~r_hsync_d;
  assign vsync_rise   = vsync & ~r_vsync_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_x       <= '0;
      r_y       <= '0;
      r_vde_d   <= 1'b0;
      r_hsync_d <= 1'b0;
      r_vsync_d <= 1'b0;
    end else begin
      r_vde_d   <= vde;
      r_hsync_d <= hsync;
      r_vsync_d <= vsync;

      if (w_vde_fall || w_hsync_rise) r_x <= '0;
      else if (vde)                   r_x <= r_x + 1'b1;

      if (vsync_rise)      r_y <= '0;
      else if (w_vde_fall) r_y <= r_y + 1'b1;
    end
  end

  // X/Y are the coordinates of the pixel presented this cycle.
  assign w_x_in    = (32'(r_x) >= WIN_X0) && (32'(r_x) < X_HI);
  assign w_y_in    = (32'(r_y) >= WIN_Y0) && (32'(r_y) < Y_HI);
  assign in_window = vde && w_x_in && w_y_in;

endmodule

`default_nettype wire

// File: rtl/rgb_frame_avg.sv
// ============================================================================
// Module : rgb_frame_avg
// Brief  : Per-frame average of a 2^W x 2^H RGB window, with optional colour
//          classification enabled by macro RGB_AVG_CLASS_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rgb_frame_avg
  import rgb_avg_pkg::*;
#(
  parameter int WIN_X0     = 608,
  parameter int WIN_Y0     = 328,
  parameter int WIN_W_LOG2 = 6,
  parameter int WIN_H_LOG2 = 6
) (
  input  logic             clk_100MHz,
  input  logic             Rst,
  input  logic [RGB_W-1:0] RGB_Data,
  input  logic             RGB_HSync,
  input  logic             RGB_VSync,
  input  logic             RGB_VDE,
  output logic [RGB_W-1:0] Avg_Data,
  output logic             Avg_Valid,
  output logic             Short_Frame,
  output logic [1:0]       Colour_Class
);

  localparam int               SHIFT = WIN_W_LOG2 + WIN_H_LOG2;
  localparam int               SUM_W = CH_W + SHIFT;
  localparam int               CNT_W = SHIFT + 1;
  localparam logic [CNT_W-1:0] FULL  = CNT_W'(1) << SHIFT;

  avg_state_t       r_state;
  logic [SUM_W-1:0] r_sum_r;
  logic [SUM_W-1:0] r_sum_g;
  logic [SUM_W-1:0] r_sum_b;
  logic [CNT_W-1:0] r_count;
  logic [RGB_W-1:0] r_avg_data;
  logic             r_avg_valid;
  logic             r_short_frame;
  logic             w_in_window;
  logic             w_vsync_rise;
  logic [RGB_W-1:0] w_avg;

  rgb_win_counter #(
    .WIN_X0     (WIN_X0),
    .WIN_Y0     (WIN_Y0),
    .WIN_W_LOG2 (WIN_W_LOG2),
    .WIN_H_LOG2 (WIN_H_LOG2)
  ) u_win_counter (
    .clk        (clk_100MHz),
    .rst        (Rst),
    .hsync      (RGB_HSync),
    .vsync      (RGB_VSync),
    .vde        (RGB_VDE),
    .in_window  (w_in_window),
    .vsync_rise (w_vsync_rise)
  );

  // Sum width is exactly CH_W+SHIFT, so its top byte is the divided result.
  assign w_avg = {r_sum_r[SUM_W-1 -: CH_W], r_sum_g[SUM_W-1 -: CH_W], r_sum_b[SUM_W-1 -: CH_W]};

`ifdef RGB_AVG_CLASS_EN
  logic [1:0] r_class;
`endif

  always_ff @(posedge clk_100MHz or posedge Rst) begin
    if (Rst) begin
      r_state       <= ST_WAIT_FRAME;
      r_sum_r       <= '0;
      r_sum_g       <= '0;
      r_sum_b       <= '0;
      r_count       <= '0;
      r_avg_data    <= '0;
      r_avg_valid   <= 1'b0;
      r_short_frame <= 1'b0;
`ifdef RGB_AVG_CLASS_EN
      r_class       <= CLASS_NEUTRAL;
`endif
    end else begin
      r_avg_valid   <= 1'b0;
      r_short_frame <= 1'b0;
      case (r_state)
        ST_WAIT_FRAME: begin
          if (w_vsync_rise) r_state <= ST_ACCUM;
        end
        ST_ACCUM: begin
          if (w_in_window) begin
            r_sum_r <= r_sum_r + SUM_W'(RGB_Data[23:16]);
            r_sum_g <= r_sum_g + SUM_W'(RGB_Data[15:8]);
            r_sum_b <= r_sum_b + SUM_W'(RGB_Data[7:0]);
            r_count <= r_count + 1'b1;
          end
          if (w_vsync_rise) r_state <= ST_FINISH;
        end
        ST_FINISH: begin
          if (r_count == FULL) begin
            r_avg_data  <= w_avg;
            r_avg_valid <= 1'b1;
`ifdef RGB_AVG_CLASS_EN
            r_class     <= classify(w_avg);
`endif
          end else begin
            r_short_frame <= 1'b1;
          end
          // Pixels arriving in this cycle are dropped along with the old sums.
          r_sum_r <= '0;
          r_sum_g <= '0;
          r_sum_b <= '0;
          r_count <= '0;
          r_state <= ST_ACCUM;
        end
        default: r_state <= ST_WAIT_FRAME;
      endcase
    end
  end

  assign Avg_Data    = r_avg_data;
  assign Avg_Valid   = r_avg_valid;
  assign Short_Frame = r_short_frame;
`ifdef RGB_AVG_CLASS_EN
  assign Colour_Class = r_class;
`else
  assign Colour_Class = CLASS_NEUTRAL;
`endif

endmodule

`default_nettype wire

// File: tb/tb_rgb_frame_avg.sv
// ============================================================================
// Module : tb_rgb_frame_avg
// Brief  : Randomised self-checking bench for rgb_frame_avg (4x4 window).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_rgb_frame_avg;

  localparam int X0 = 3;
  localparam int Y0 = 2;
  localparam int WL = 2;
  localparam int HL = 2;
  localparam int LINE_W = 10;
  localparam int MAX_LINES = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [23:0] rgb_data = '0;
  logic        hsync = 1'b0;
  logic        vsync = 1'b0;
  logic        vde = 1'b0;
  logic [23:0] avg_data;
  logic        avg_valid;
  logic        short_frame;
  logic [1:0]  colour_class;

  rgb_frame_avg #(
    .WIN_X0     (X0),
    .WIN_Y0     (Y0),
    .WIN_W_LOG2 (WL),
    .WIN_H_LOG2 (HL)
  ) dut (
    .clk_100MHz   (clk),
    .Rst          (rst),
    .RGB_Data     (rgb_data),
    .RGB_HSync    (hsync),
    .RGB_VSync    (vsync),
    .RGB_VDE      (vde),
    .Avg_Data     (avg_data),
    .Avg_Valid    (avg_valid),
    .Short_Frame  (short_frame),
    .Colour_Class (colour_class)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int valid_tot = 0;
  int short_tot = 0;
  int valid_cyc = 0;
  always @(negedge clk) begin
    if (avg_valid) begin
      valid_tot = valid_tot + 1;
      valid_cyc = cyc;
    end
    if (short_frame) short_tot = short_tot + 1;
  end

  int errors = 0;
  int checks = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model state
  logic [23:0] frame_pix [MAX_LINES][LINE_W];
  logic [23:0] cur_avg = '0;
  logic [1:0]  cur_cls = '0;
  bit          armed = 1'b0;
  bit          exp_valid;
  bit          exp_short;

  function automatic logic [1:0] ref_class(input logic [23:0] p);
    int r, g, b;
    logic [1:0] c;
    r = int'(p[23:16]);
    g = int'(p[15:8]);
    b = int'(p[7:0]);
    c = 2'd0;
    if (r - g >= 32 && r - b >= 32) c = 2'd1;
    if (g - r >= 32 && g - b >= 32) c = 2'd2;
    if (b - r >= 32 && b - g >= 32) c = 2'd3;
`ifndef RGB_AVG_CLASS_EN
    c = 2'd0;
`endif
    return c;
  endfunction

  // mode 0: uniform colour, 1: alternating columns FF0000/000000, 2: random
  task automatic fill(input int mode, input logic [23:0] colour);
    for (int r = 0; r < MAX_LINES; r++)
      for (int c = 0; c < LINE_W; c++)
        case (mode)
          0:       frame_pix[r][c] = colour;
          1:       frame_pix[r][c] = (c % 2 == 0) ? 24'hFF0000 : 24'h000000;
          default: frame_pix[r][c] = 24'($urandom);
        endcase
  endtask

  task automatic model_frame(input int nlines);
    int sr, sg, sb, n;
    sr = 0; sg = 0; sb = 0; n = 0;
    for (int r = 0; r < nlines; r++)
      for (int c = 0; c < LINE_W; c++)
        if (r >= Y0 && r < Y0 + (1 << HL) && c >= X0 && c < X0 + (1 << WL)) begin
          sr += int'(frame_pix[r][c][23:16]);
          sg += int'(frame_pix[r][c][15:8]);
          sb += int'(frame_pix[r][c][7:0]);
          n++;
        end
    exp_valid = armed && (n == (1 << (WL + HL)));
    exp_short = armed && !exp_valid;
    if (exp_valid) begin
      cur_avg = {8'(sr / n), 8'(sg / n), 8'(sb / n)};
      cur_cls = ref_class(cur_avg);
    end
  endtask

  task automatic send_line(input int row);
    for (int c = 0; c < LINE_W; c++) begin
      @(negedge clk);
      vde = 1'b1;
      rgb_data = frame_pix[row][c];
    end
    @(negedge clk);
    vde = 1'b0;
    rgb_data = 24'hFFFFFF;
    @(negedge clk);
    hsync = 1'b1;
    @(negedge clk);
    hsync = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_frame(input int nlines);
    for (int r = 0; r < nlines; r++) send_line(r);
    model_frame(nlines);
  endtask

  task automatic close_frame(input string tag);
    int v0, s0, rise_cyc;
    v0 = valid_tot;
    s0 = short_tot;
    @(negedge clk);
    vsync = 1'b1;
    rise_cyc = cyc;
    repeat (3) @(negedge clk);
    vsync = 1'b0;
    repeat (5) @(negedge clk);
    check_val({tag, ".valid_pulses"}, 32'(valid_tot - v0), 32'(exp_valid));
    check_val({tag, ".short_pulses"}, 32'(short_tot - s0), 32'(exp_short));
    check_val({tag, ".avg_data"}, 32'(avg_data), 32'(cur_avg));
    check_val({tag, ".class"}, 32'(colour_class), 32'(cur_cls));
    if (exp_valid) check_val({tag, ".latency"}, 32'(valid_cyc - rise_cyc), 32'd2);
    armed = 1'b1;
  endtask

  task automatic check_outputs_zero(input string tag);
    check_val({tag, ".avg_data"}, 32'(avg_data), 32'h0);
    check_val({tag, ".avg_valid"}, 32'(avg_valid), 32'h0);
    check_val({tag, ".short_frame"}, 32'(short_frame), 32'h0);
    check_val({tag, ".class"}, 32'(colour_class), 32'h0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Partial frame before any VSync: ignored, first rise gives nothing.
    fill(0, 24'h804020);
    send_frame(5);
    close_frame("pre_vsync");

    fill(0, 24'h804020);
    send_frame(8);
    close_frame("uniform_804020");

    fill(1, 24'h0);
    send_frame(8);
    close_frame("alternating");

    fill(2, 24'h0);
    send_frame(4);
    close_frame("short_frame");

    fill(0, 24'h606060);
    send_frame(8);
    close_frame("neutral_606060");

    fill(0, 24'h2080FF);
    send_frame(8);
    close_frame("blue_2080FF");

    for (int i = 0; i < 4; i++) begin
      fill(2, 24'h0);
      send_frame(8);
      close_frame($sformatf("random%0d", i));
    end

    fill(0, 24'h804020);
    send_frame(8);
    close_frame("pre_reset");

    // Reset in the middle of an in-window line.
    fill(2, 24'h0);
    for (int r = 0; r < 3; r++) send_line(r);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      vde = 1'b1;
      rgb_data = frame_pix[3][c];
    end
    #2 rst = 1'b1;
    #1 check_outputs_zero("async_reset");
    @(negedge clk);
    vde = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    armed = 1'b0;
    cur_avg = '0;
    cur_cls = '0;
    send_frame(3);
    close_frame("post_reset_first_vsync");

    fill(2, 24'h0);
    send_frame(8);
    close_frame("post_reset_full");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/rgb_frame_avg.md
RGB_FRAME_AVG -- requirements
Module: rgb_frame_avg

Interface
REQ-001 SHALL have parameter WIN_X0, default 608, first active column of the averaging window.
REQ-002 SHALL have parameter WIN_Y0, default 328, first active row of the averaging window.
REQ-003 SHALL have parameter WIN_W_LOG2, default 6, window width = 2^WIN_W_LOG2 pixels.
REQ-004 SHALL have parameter WIN_H_LOG2, default 6, window height = 2^WIN_H_LOG2 rows.
REQ-005 SHALL have port clk_100MHz input 1, the single clock; all logic in this one domain.
REQ-006 SHALL have port Rst input 1, asynchronous active-high reset.
REQ-007 SHALL have port RGB_Data input 24, camera pixel as {R[23:16],G[15:8],B[7:0]}.
REQ-008 SHALL have port RGB_HSync input 1, line sync, active-high, unused except for the line-end fallback.
REQ-009 SHALL have port RGB_VSync input 1, frame sync, active-high; its rising edge marks frame boundary.
REQ-010 SHALL have port RGB_VDE input 1, pixel valid; one pixel per cycle while high.
REQ-011 SHALL have port Avg_Data output 24, last completed window average, same packing as RGB_Data.
REQ-012 SHALL have port Avg_Valid output 1, one-cycle pulse when Avg_Data updates.
REQ-013 SHALL have port Short_Frame output 1, one-cycle pulse when a frame ended before the window completed.
REQ-014 SHALL have port Colour_Class output 2, 0 neutral, 1 red, 2 green, 3 blue dominant.

Function
REQ-015 SHALL track column X (12 bits): +1 per VDE cycle; cleared on VDE falling edge or HSync rising edge.
REQ-016 SHALL track row Y (11 bits): +1 on each VDE falling edge; cleared on VSync rising edge.
REQ-017 SHALL treat a pixel as in-window when VDE=1, WIN_X0<=X<WIN_X0+2^W, WIN_Y0<=Y<WIN_Y0+2^H.
REQ-018 SHALL accumulate each channel into an unsigned sum of 8+W+H bits; no overflow possible; in-window pixel count kept in W+H+1 bits.
REQ-019 SHALL run FSM WAIT_FRAME -> ACCUM -> FINISH -> ACCUM: WAIT_FRAME exits on first VSync rise; ACCUM exits on every VSync rise; FINISH lasts exactly one cycle.
REQ-020 SHALL in FINISH, if count == 2^(W+H), load Avg_Data = each sum >> (W+H) and pulse Avg_Valid the next cycle (latency: 2 cycles from VSync rise).
REQ-021 SHALL in FINISH, if count < 2^(W+H), hold Avg_Data, pulse Short_Frame, not pulse Avg_Valid.
REQ-022 SHALL clear sums and count in FINISH so the next frame starts from zero; a pixel with VDE=1 during FINISH is ignored.
REQ-023 SHALL ignore pixels in WAIT_FRAME (first partial frame never reported).
REQ-024 SHALL hold Avg_Data and Colour_Class stable between Avg_Valid pulses.

Reset
REQ-025 SHALL on Rst: FSM=WAIT_FRAME, X=Y=0, sums=count=0, Avg_Data=24'h000000, Avg_Valid=0, Short_Frame=0, Colour_Class=0.
REQ-026 SHALL on Rst mid-frame discard the partial accumulation and require a new VSync rise before accumulating.

Configuration
REQ-027 SHALL with RGB_AVG_CLASS_EN defined: load Colour_Class with Avg_Data; class = channel exceeding both others by >=32, else 0; ties -> 0.
REQ-028 SHALL with RGB_AVG_CLASS_EN undefined: hold Colour_Class at 0, no comparator logic.

Structure
REQ-029 SHALL place FSM state enum, pixel/sum width constants and class codes in package rgb_avg_pkg.
REQ-030 SHALL implement X/Y tracking and in-window decode in sub-module rgb_win_counter.

Verification
REQ-031 SHALL check: W=H=2, uniform pixel 24'h804020 over full frame -> Avg_Valid once, Avg_Data=24'h804020, class 1 (if EN).
REQ-032 SHALL check: W=H=2, window pixels alternating 24'hFF0000/24'h000000 -> Avg_Data=24'h7F0000.
REQ-033 SHALL check: frame with only 2 of 4 window rows then VSync rise -> Short_Frame pulse, Avg_Valid 0, Avg_Data unchanged.
REQ-034 SHALL check: first frame after Rst arriving mid-frame -> no output until second VSync rise.
REQ-035 SHALL check: Rst asserted mid-window -> all outputs 0 within same cycle, next full frame averages correctly.
REQ-036 SHALL check: uniform 24'h606060 -> Colour_Class=0; 24'h2080FF -> Colour_Class=3 (EN) / 0 (not EN).
